noc_injection_throttle: RTL and testbench

Congestion-aware admission controller between a tile's injection interface and the `noc_router_enhanced` local input port. It samples the router's `predicted_congestion_milli` EMA and sequences tile injection through three states: OPEN (full rate), THROTTLE (token-bucket rate limit) and BLOCK (injection halted, with a starvation guard). It exposes its state and stall statistics for the perf-counter path.

---
 rtl/noc_injection_throttle.sv | 183 ++++++++++++++++++
 tb/tb_noc_injection_throttle.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_injection_throttle.sv
// Congestion-aware injection throttle: OPEN / THROTTLE (token bucket) / BLOCK in front of the router local port.
// Optional starvation guard in BLOCK is compiled when NOC_THROTTLE_STARVE_GUARD_EN is defined.
module noc_injection_throttle #(
    parameter int FLIT_WIDTH       = 64,
    parameter int HI_MILLI         = 900,
    parameter int LO_MILLI         = 700,
    parameter int BLOCK_MILLI      = 980,
    parameter int BUCKET_MAX       = 8,
    parameter int REFILL_PERIOD    = 4,
    parameter int MAX_BLOCK_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [15:0]           pred_cong_milli,
    input  logic [FLIT_WIDTH-1:0] tile_flit_in,
    input  logic                  tile_valid_in,
    output logic                  tile_ready_out,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [1:0]            state_out,
    output logic [7:0]            tokens_out,
    output logic [31:0]           throttled_cycles,
    output logic [15:0]           forced_grants
);

    localparam logic [1:0] ST_OPEN     = 2'd0;
    localparam logic [1:0] ST_THROTTLE = 2'd1;
    localparam logic [1:0] ST_BLOCK    = 2'd2;

    localparam logic [15:0] L_HI     = 16'(HI_MILLI);
    localparam logic [15:0] L_LO     = 16'(LO_MILLI);
    localparam logic [15:0] L_BLOCK  = 16'(BLOCK_MILLI);
    localparam logic [7:0]  L_BMAX   = 8'(BUCKET_MAX);
    localparam logic [7:0]  L_RLAST  = 8'(REFILL_PERIOD - 1);

    // Elaboration-time parameter legality checks.
    if (LO_MILLI >= HI_MILLI || BLOCK_MILLI <= HI_MILLI) begin : g_bad_levels
        $error("noc_injection_throttle: need LO_MILLI < HI_MILLI < BLOCK_MILLI");
    end
    if (BUCKET_MAX < 1 || BUCKET_MAX > 255 || REFILL_PERIOD < 1 || REFILL_PERIOD > 255) begin : g_bad_bucket
        $error("noc_injection_throttle: BUCKET_MAX and REFILL_PERIOD must be 1..255");
    end
    if (MAX_BLOCK_CYCLES < 2 || MAX_BLOCK_CYCLES > 65535) begin : g_bad_starve
        $error("noc_injection_throttle: MAX_BLOCK_CYCLES must be 2..65535");
    end

    function automatic logic [7:0] tok_inc(input logic [7:0] t);
        return (t >= L_BMAX) ? L_BMAX : t + 8'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_pred_q;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  r_tokens;
    logic [7:0]  w_tokens_nxt;
    logic [7:0]  r_refill;
    logic [31:0] r_throttled;
    logic        w_allow;
    logic        w_force;
    logic        w_xfer;
    logic        w_refill_wrap;

    // allow is purely registered, so ready_in never reaches valid_out.
    assign flit_out         = tile_flit_in;
    assign valid_out        = tile_valid_in & w_allow;
    assign tile_ready_out   = ready_in & w_allow;
    assign w_xfer           = valid_out & ready_in;
    assign state_out        = r_state;
    assign tokens_out       = r_tokens;
    assign throttled_cycles = r_throttled;
    assign w_refill_wrap    = (r_refill == L_RLAST);

    always_comb begin
        w_allow = 1'b0;
        case (r_state)
            ST_OPEN:     w_allow = 1'b1;
            ST_THROTTLE: w_allow = (r_tokens != 8'd0);
            ST_BLOCK:    w_allow = w_force;
            default:     w_allow = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_pred_q >= L_BLOCK) begin
            w_state_nxt = ST_BLOCK;
        end else begin
            case (r_state)
                ST_OPEN:     if (r_pred_q >= L_HI) w_state_nxt = ST_THROTTLE;
                ST_THROTTLE: if (r_pred_q <  L_LO) w_state_nxt = ST_OPEN;
                ST_BLOCK:    if (r_pred_q <  L_HI) w_state_nxt = ST_THROTTLE;
                default:     w_state_nxt = ST_OPEN;
            endcase
        end
    end

    // A simultaneous refill and consume leaves the bucket unchanged.
    always_comb begin
        w_tokens_nxt = r_tokens;
        case (r_state)
            ST_OPEN: w_tokens_nxt = tok_inc(r_tokens);
            ST_THROTTLE: begin
                if (w_refill_wrap && !w_xfer) begin
                    w_tokens_nxt = tok_inc(r_tokens);
                end else if (!w_refill_wrap && w_xfer && r_tokens != 8'd0) begin
                    w_tokens_nxt = r_tokens - 8'd1;
                end
            end
            default: w_tokens_nxt = r_tokens;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pred_q    <= 16'd0;
            r_state     <= ST_OPEN;
            r_tokens    <= L_BMAX;
            r_refill    <= 8'd0;
            r_throttled <= 32'd0;
        end else begin
            r_pred_q <= pred_cong_milli;
            r_state  <= w_state_nxt;
            r_tokens <= w_tokens_nxt;
            // Held at zero outside THROTTLE so every entry starts a fresh period.
            if (r_state == ST_THROTTLE) begin
                r_refill <= w_refill_wrap ? 8'd0 : r_refill + 8'd1;
            end else begin
                r_refill <= 8'd0;
            end
            if (tile_valid_in && !w_allow) begin
                r_throttled <= sat_inc32(r_throttled);
            end
        end
    end

`ifdef NOC_THROTTLE_STARVE_GUARD_EN
    localparam logic [15:0] L_STARVE_ARM = 16'(MAX_BLOCK_CYCLES - 2);

    logic [15:0] r_starve;
    logic        r_force;
    logic [15:0] r_forced_grants;

    assign w_force       = r_force;
    assign forced_grants = r_forced_grants;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve        <= 16'd0;
            r_force         <= 1'b0;
            r_forced_grants <= 16'd0;
        end else begin
            if (r_state == ST_BLOCK && r_force && w_xfer) begin
                r_forced_grants <= sat_inc16(r_forced_grants);
            end
            if (r_state != ST_BLOCK || w_state_nxt != ST_BLOCK || w_xfer) begin
                r_starve <= 16'd0;
                r_force  <= 1'b0;
            end else if (!tile_valid_in) begin
                // force survives a dropped valid; only a transfer or exit retires it.
                r_starve <= 16'd0;
            end else if (!r_force) begin
                r_starve <= r_starve + 16'd1;
                if (r_starve == L_STARVE_ARM) begin
                    r_force <= 1'b1;
                end
            end
        end
    end
`else
    assign w_force       = 1'b0;
    assign forced_grants = 16'd0;
`endif

endmodule

// File: tb/tb_noc_injection_throttle.sv
// Directed, table-driven bench for noc_injection_throttle (default parameters).
module tb_noc_injection_throttle;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pred_cong_milli;
    logic [63:0] tile_flit_in;
    logic        tile_valid_in;
    logic        tile_ready_out;
    logic [63:0] flit_out;
    logic        valid_out;
    logic        ready_in;
    logic [1:0]  state_out;
    logic [7:0]  tokens_out;
    logic [31:0] throttled_cycles;
    logic [15:0] forced_grants;

    always #5 clk = ~clk;

    noc_injection_throttle dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pred_cong_milli  (pred_cong_milli),
        .tile_flit_in     (tile_flit_in),
        .tile_valid_in    (tile_valid_in),
        .tile_ready_out   (tile_ready_out),
        .flit_out         (flit_out),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .state_out        (state_out),
        .tokens_out       (tokens_out),
        .throttled_cycles (throttled_cycles),
        .forced_grants    (forced_grants)
    );

    typedef struct {
        logic [15:0] pred;
        logic        v;
        logic        r;
        logic [1:0]  st;
        logic [7:0]  tok;
        logic        vo;
        logic        tr;
    } vec_t;

    vec_t tv[33];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   xfers    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] p, input logic v, input logic r);
        pred_cong_milli = p;
        tile_valid_in   = v;
        ready_in        = r;
        tile_flit_in    = {$urandom(), $urandom()};
        #1;
    endtask

    task automatic tick();
        if (valid_out && ready_in) xfers++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input int i);
        drive(tv[i].pred, tv[i].v, tv[i].r);
        chk($sformatf("vec%0d_state", i), 64'(state_out), 64'(tv[i].st));
        chk($sformatf("vec%0d_tokens", i), 64'(tokens_out), 64'(tv[i].tok));
        chk($sformatf("vec%0d_valid_out", i), 64'(valid_out), 64'(tv[i].vo));
        chk($sformatf("vec%0d_tile_ready", i), 64'(tile_ready_out), 64'(tv[i].tr));
        tick();
    endtask

    initial begin
        // THROTTLE entry and rate (pred 950, continuous valid/ready)
        tv[0]  = '{950, 1, 1, 0, 8, 1, 1};
        tv[1]  = '{950, 1, 1, 0, 8, 1, 1};
        tv[2]  = '{950, 1, 1, 1, 8, 1, 1};
        tv[3]  = '{950, 1, 1, 1, 7, 1, 1};
        tv[4]  = '{950, 1, 1, 1, 6, 1, 1};
        tv[5]  = '{950, 1, 1, 1, 5, 1, 1};
        tv[6]  = '{950, 1, 1, 1, 5, 1, 1};
        tv[7]  = '{950, 1, 1, 1, 4, 1, 1};
        tv[8]  = '{950, 1, 1, 1, 3, 1, 1};
        tv[9]  = '{950, 1, 1, 1, 2, 1, 1};
        tv[10] = '{950, 1, 1, 1, 2, 1, 1};
        tv[11] = '{950, 1, 1, 1, 1, 1, 1};
        tv[12] = '{950, 1, 1, 1, 0, 0, 0};
        tv[13] = '{950, 1, 1, 1, 0, 0, 0};
        tv[14] = '{950, 1, 1, 1, 1, 1, 1};
        tv[15] = '{950, 1, 1, 1, 0, 0, 0};
        tv[16] = '{950, 1, 1, 1, 0, 0, 0};
        tv[17] = '{950, 1, 1, 1, 0, 0, 0};
        tv[18] = '{950, 1, 1, 1, 1, 1, 1};
        // Hysteresis: 800 holds THROTTLE, 650 returns to OPEN, bucket refills +1/cycle
        tv[19] = '{800, 0, 1, 1, 1, 0, 1};
        tv[20] = '{800, 0, 1, 1, 1, 0, 1};
        tv[21] = '{800, 0, 1, 1, 1, 0, 1};
        tv[22] = '{800, 0, 1, 1, 1, 0, 1};
        tv[23] = '{650, 0, 1, 1, 2, 0, 1};
        tv[24] = '{650, 0, 1, 1, 2, 0, 1};
        tv[25] = '{650, 0, 1, 0, 2, 0, 1};
        tv[26] = '{650, 0, 1, 0, 3, 0, 1};
        tv[27] = '{650, 0, 1, 0, 4, 0, 1};
        tv[28] = '{650, 0, 1, 0, 5, 0, 1};
        tv[29] = '{650, 0, 1, 0, 6, 0, 1};
        tv[30] = '{650, 0, 1, 0, 7, 0, 1};
        tv[31] = '{650, 0, 1, 0, 8, 0, 1};
        tv[32] = '{650, 0, 1, 0, 8, 0, 1};

        // Reset and OPEN
        reset_n         = 1'b0;
        pred_cong_milli = 16'd0;
        tile_flit_in    = 64'd0;
        tile_valid_in   = 1'b1;
        ready_in        = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_state", 64'(state_out), 64'd0);
        chk("reset_tokens", 64'(tokens_out), 64'd8);
        chk("reset_throttled", 64'(throttled_cycles), 64'd0);
        chk("reset_forced", 64'(forced_grants), 64'd0);
        chk("reset_valid_out", 64'(valid_out), 64'd1);
        chk("reset_tile_ready", 64'(tile_ready_out), 64'd1);
        reset_n = 1'b1;

        xfers = 0;
        for (int i = 0; i < 20; i++) begin
            drive(16'd0, 1'b1, 1'b1);
            chk("open_flit", flit_out, tile_flit_in);
            tick();
        end
        chk("open_xfers", 64'(xfers), 64'd20);
        chk("open_state", 64'(state_out), 64'd0);
        chk("open_tokens", 64'(tokens_out), 64'd8);
        chk("open_throttled", 64'(throttled_cycles), 64'd0);

        // THROTTLE rate
        for (int i = 0; i <= 18; i++) apply_vec(i);
        xfers = 0;
        for (int i = 0; i < 35; i++) begin
            drive(16'd950, 1'b1, 1'b1);
            tick();
        end
        chk("throttle_rate_xfers", 64'(xfers), 64'd8);
        chk("throttle_throttled", 64'(throttled_cycles), 64'd32);

        // Hysteresis
        for (int i = 19; i <= 32; i++) apply_vec(i);
        chk("hyst_throttled", 64'(throttled_cycles), 64'd32);

        // Fresh start for BLOCK
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst2_throttled", 64'(throttled_cycles), 64'd0);
        chk("rst2_state", 64'(state_out), 64'd0);
        reset_n = 1'b1;

        xfers = 0;
`ifdef NOC_THROTTLE_STARVE_GUARD_EN
        for (int b = 0; b <= 68; b++) begin
            drive(16'd1000, 1'b1, (b >= 65 && b <= 67) ? 1'b0 : 1'b1);
            chk($sformatf("blk%0d_valid_out", b), 64'(valid_out), (b < 2 || b >= 65) ? 64'd1 : 64'd0);
            chk($sformatf("blk%0d_tile_ready", b), 64'(tile_ready_out),
                (b < 2 || b == 68) ? 64'd1 : 64'd0);
            tick();
        end
        chk("blk_xfers", 64'(xfers), 64'd3);
        chk("blk_forced", 64'(forced_grants), 64'd1);
        chk("blk_throttled", 64'(throttled_cycles), 64'd63);
`else
        for (int b = 0; b < 200; b++) begin
            drive(16'd1000, 1'b1, (b >= 65 && b <= 67) ? 1'b0 : 1'b1);
            chk($sformatf("blk%0d_valid_out", b), 64'(valid_out), (b < 2) ? 64'd1 : 64'd0);
            tick();
        end
        chk("blk_xfers", 64'(xfers), 64'd2);
        chk("blk_forced", 64'(forced_grants), 64'd0);
        chk("blk_throttled", 64'(throttled_cycles), 64'd198);
`endif
        chk("blk_state", 64'(state_out), 64'd2);
        chk("blk_tokens", 64'(tokens_out), 64'd8);

        // BLOCK -> THROTTLE at 850, drain bucket to 2, then async reset mid-cycle
        xfers = 0;
        for (int a = 0; a < 9; a++) begin
            drive(16'd850, 1'b1, 1'b1);
            tick();
        end
        chk("rec_xfers", 64'(xfers), 64'd7);
        drive(16'd850, 1'b1, 1'b1);
        chk("rec_state", 64'(state_out), 64'd1);
        chk("rec_tokens", 64'(tokens_out), 64'd2);
`ifdef NOC_THROTTLE_STARVE_GUARD_EN
        chk("rec_throttled", 64'(throttled_cycles), 64'd65);
`else
        chk("rec_throttled", 64'(throttled_cycles), 64'd200);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_state", 64'(state_out), 64'd0);
        chk("async_tokens", 64'(tokens_out), 64'd8);
        chk("async_throttled", 64'(throttled_cycles), 64'd0);
        chk("async_forced", 64'(forced_grants), 64'd0);
        chk("async_valid_out", 64'(valid_out), 64'd1);
        #3;
        reset_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
